// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared types and constants for the load-use interlock
package hazard_pkg;

    typedef enum logic {
        RUN      = 1'b0,
        LU_STALL = 1'b1
    } hz_state_t;

    // Register index 0 reads as zero, so a load targeting it never creates a dependency.
    localparam int unsigned ZERO_REG = 0;

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating event counter used for the bubble count
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (inc && (count != {W{1'b1}})) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/load_use_hazard_ctrl.sv
// rtl/load_use_hazard_ctrl.sv - IF/ID load-use interlock; optional macro LOAD_STORE_FWD_EN
module load_use_hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int REG_AW     = 4,
    parameter int LOAD_STALL = 1,
    parameter int CNT_W      = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              idex_mem_read,
    input  logic [REG_AW-1:0] idex_rd,
    input  logic [REG_AW-1:0] ifid_rs,
    input  logic [REG_AW-1:0] ifid_rt,
    input  logic              ifid_rs_used,
    input  logic              ifid_rt_used,
    input  logic              ifid_mem_write,
    input  logic              mem_busy,
    input  logic              branch_flush,
    output logic              pc_write,
    output logic              ifid_write,
    output logic              ctrl_select,
    output logic              exmem_write,
    output logic [CNT_W-1:0]  bubble_count
);

    localparam int CW = $clog2(LOAD_STALL + 1);
    localparam logic [REG_AW-1:0] ZERO_IDX   = REG_AW'(ZERO_REG);
    localparam logic [CW-1:0]     CNT_RELOAD = CW'(LOAD_STALL - 1);

    hz_state_t      state, state_n;
    logic [CW-1:0]  cnt, cnt_n;
    logic           rt_store_ok;
    logic           hazard;

`ifdef LOAD_STORE_FWD_EN
    // Store data is forwarded MEM->MEM, so only address-side (rs) dependencies stall stores.
    assign rt_store_ok = ~ifid_mem_write;
`else
    logic unused_store_flag;
    assign unused_store_flag = ifid_mem_write;
    assign rt_store_ok       = 1'b1;
`endif

    assign hazard = idex_mem_read && (idex_rd != ZERO_IDX) &&
                    ((ifid_rs_used && (ifid_rs == idex_rd)) ||
                     (ifid_rt_used && (ifid_rt == idex_rd) && rt_store_ok));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RUN;
            cnt   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    always_comb begin
        state_n     = state;
        cnt_n       = cnt;
        pc_write    = 1'b1;
        ifid_write  = 1'b1;
        ctrl_select = 1'b1;
        exmem_write = 1'b1;
        // Enables are combinational, so reset must also force them open directly.
        if (!rst_n) begin
            state_n = RUN;
            cnt_n   = '0;
        end else if (mem_busy) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            exmem_write = 1'b0;
        end else begin
            unique case (state)
                RUN: begin
                    if (!branch_flush && hazard) begin
                        pc_write    = 1'b0;
                        ifid_write  = 1'b0;
                        ctrl_select = 1'b0;
                        if (LOAD_STALL > 1) begin
                            state_n = LU_STALL;
                            cnt_n   = CNT_RELOAD;
                        end
                    end
                end
                LU_STALL: begin
                    if (branch_flush) begin
                        state_n = RUN;
                        cnt_n   = '0;
                    end else begin
                        pc_write    = 1'b0;
                        ifid_write  = 1'b0;
                        ctrl_select = 1'b0;
                        cnt_n       = cnt - CW'(1);
                        if (cnt == CW'(1)) begin
                            state_n = RUN;
                        end
                    end
                end
                default: begin
                    state_n = RUN;
                    cnt_n   = '0;
                end
            endcase
        end
    end

    sat_counter #(
        .W (CNT_W)
    ) u_bubble_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (~ctrl_select),
        .count (bubble_count)
    );

endmodule
